// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between PC selection, the instruction cache and
// the IFID register. It owns the fetch PC and keeps at most one Icache read
// outstanding (req/gnt/rvalid). The returned word is held for IFID under a
// valid/ready handshake. Branch (EX) and exception (Ctrl) redirects squash
// any in-flight or held fetch; branch has priority over exception.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ex_branch_flag/ex_branch_pc   branch redirect request and target
//   ctrl_excp_flag/ctrl_excp_pc   exception redirect request and vector
//   ic_req/ic_addr                Icache read request and address (= fetch PC)
//   ic_gnt                        Icache accepted the request this cycle
//   ic_rvalid/ic_rdata            Icache read data valid and instruction word
//   if_valid/if_pc/if_instr       instruction presented to IFID
//   if_ready                      IFID accepts the presented instruction
//   if_16bit                      presented instruction is compressed
//   busy                          Icache request outstanding (REQ or WAIT)
module fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_branch_flag,
    input  logic [ADDR_WIDTH-1:0] ex_branch_pc,
    input  logic                  ctrl_excp_flag,
    input  logic [ADDR_WIDTH-1:0] ctrl_excp_pc,
    output logic                  ic_req,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    input  logic                  ic_gnt,
    input  logic                  ic_rvalid,
    input  logic [31:0]           ic_rdata,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [31:0]           if_instr,
    input  logic                  if_ready,
    input  logic                  if_16bit,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    // Set when the outstanding Icache read was issued for a PC that has since
    // been redirected away from; its data must be discarded.
    logic                    drop;

    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   target;
    logic [ADDR_WIDTH-1:0]   step;

    always_comb begin
        redirect = ex_branch_flag | ctrl_excp_flag;
        target   = ex_branch_flag ? ex_branch_pc : ctrl_excp_pc;
        step     = if_16bit ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
    end

    assign ic_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= START_PC;
            drop     <= 1'b0;
            ic_req   <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) pc <= target;
                    state  <= S_REQ;
                    ic_req <= 1'b1;
                    busy   <= 1'b1;
                end

                S_REQ: begin
                    // The address may change before gnt; a redirect that
                    // coincides with gnt leaves a stale read in flight.
                    if (redirect) pc <= target;
                    if (ic_gnt) begin
                        state  <= S_WAIT;
                        ic_req <= 1'b0;
                        drop   <= redirect;
                    end
                end

                S_WAIT: begin
                    if (ic_rvalid) begin
                        if (drop || redirect) begin
                            if (redirect) pc <= target;
                            drop   <= 1'b0;
                            state  <= S_REQ;
                            ic_req <= 1'b1;
                        end else begin
                            state    <= S_HOLD;
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_instr <= ic_rdata;
                            busy     <= 1'b0;
                        end
                    end else if (redirect) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    // A redirect overrides the sequential PC even when IFID
                    // accepts in the same cycle.
                    if (redirect || if_ready) begin
                        pc       <= redirect ? target : if_pc + step;
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                        ic_req   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed test for fetch_ctrl. Each record holds
// the inputs driven during one cycle and the outputs expected in that cycle.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_branch_flag;
    logic [31:0] ex_branch_pc;
    logic        ctrl_excp_flag;
    logic [31:0] ctrl_excp_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        if_16bit;
    logic        busy;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_WIDTH(32),
        .START_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_branch_flag(ex_branch_flag),
        .ex_branch_pc  (ex_branch_pc),
        .ctrl_excp_flag(ctrl_excp_flag),
        .ctrl_excp_pc  (ctrl_excp_pc),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_gnt        (ic_gnt),
        .ic_rvalid     (ic_rvalid),
        .ic_rdata      (ic_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_ready      (if_ready),
        .if_16bit      (if_16bit),
        .busy          (busy)
    );

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        c16;
        logic        br;
        logic [31:0] br_pc;
        logic        ex;
        logic [31:0] ex_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_busy;
    } vec_t;

    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] TOP = 32'hFFFF_FFFC;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned step_no = 0;
    vec_t        tbl[$];

    function automatic logic [31:0] ins(input int unsigned n);
        return 32'hC0DE_0000 + n;
    endfunction

    function automatic vec_t v(
        input logic rst, input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic rdy, input logic c16, input logic br, input logic [31:0] brpc,
        input logic ex, input logic [31:0] expc,
        input logic req, input logic [31:0] addr, input logic val,
        input logic [31:0] ipc, input logic [31:0] instr, input logic bsy);
        vec_t r;
        r.rst_n = rst; r.gnt = gnt; r.rvalid = rv; r.rdata = rdata;
        r.ready = rdy; r.c16 = c16; r.br = br; r.br_pc = brpc;
        r.ex = ex; r.ex_pc = expc;
        r.e_req = req; r.e_addr = addr; r.e_valid = val;
        r.e_pc = ipc; r.e_instr = instr; r.e_busy = bsy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h, expected %h", name, step_no, act, exp);
    endtask

    // Drive one cycle of inputs on the falling edge and check the outputs that
    // were registered on the preceding rising edge.
    task automatic apply(input vec_t t);
        @(negedge clk);
        rst_n          = t.rst_n;
        ic_gnt         = t.gnt;
        ic_rvalid      = t.rvalid;
        ic_rdata       = t.rdata;
        if_ready       = t.ready;
        if_16bit       = t.c16;
        ex_branch_flag = t.br;
        ex_branch_pc   = t.br_pc;
        ctrl_excp_flag = t.ex;
        ctrl_excp_pc   = t.ex_pc;
        chk("ic_req",   {31'd0, ic_req},   {31'd0, t.e_req});
        chk("ic_addr",  ic_addr,           t.e_addr);
        chk("if_valid", {31'd0, if_valid}, {31'd0, t.e_valid});
        chk("if_pc",    if_pc,             t.e_pc);
        chk("if_instr", if_instr,          t.e_instr);
        chk("busy",     {31'd0, busy},     {31'd0, t.e_busy});
        step_no++;
    endtask

    initial begin
        rst_n = 1'b0; ic_gnt = 1'b0; ic_rvalid = 1'b0; ic_rdata = '0;
        if_ready = 1'b0; if_16bit = 1'b0;
        ex_branch_flag = 1'b0; ex_branch_pc = '0;
        ctrl_excp_flag = 1'b0; ctrl_excp_pc = '0;
        repeat (2) @(negedge clk);

        //           rst gnt rv rdata   rdy c16 br brpc      ex expc     req addr     val ifpc     instr    busy
        // reset state, then back-to-back 4-byte fetches at 0x0, 0x4, 0x8
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       0, 0,       0, 0,       0,       0));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 0,       0, 0,       0,       1));
        tbl.push_back(v(1, 0, 1, ins(0), 0, 0, 0, 0,       0, 0,       0, 0,       0, 0,       0,       1));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, 0,       1, 0,       ins(0),  0));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 4,       0, 0,       ins(0),  1));
        tbl.push_back(v(1, 0, 1, ins(1), 0, 0, 0, 0,       0, 0,       0, 4,       0, 0,       ins(0),  1));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, 4,       1, 4,       ins(1),  0));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 8,       0, 4,       ins(1),  1));
        tbl.push_back(v(1, 0, 1, ins(2), 0, 0, 0, 0,       0, 0,       0, 8,       0, 4,       ins(1),  1));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, 8,       1, 8,       ins(2),  0));
        // redirect in REQ to 0x10, compressed then full-size step: 0x12, 0x16
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 1, 'h10,    0, 0,       1, 'hC,     0, 8,       ins(2),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h10,    0, 8,       ins(2),  1));
        tbl.push_back(v(1, 0, 1, ins(3), 0, 0, 0, 0,       0, 0,       0, 'h10,    0, 8,       ins(2),  1));
        tbl.push_back(v(1, 0, 0, 0,      1, 1, 0, 0,       0, 0,       0, 'h10,    1, 'h10,    ins(3),  0));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h12,    0, 'h10,    ins(3),  1));
        tbl.push_back(v(1, 0, 1, ins(4), 0, 0, 0, 0,       0, 0,       0, 'h12,    0, 'h10,    ins(3),  1));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, 'h12,    1, 'h12,    ins(4),  0));
        // branch to 0x100 while waiting on 0x20; stale rvalid two cycles later
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 1, 'h20,    0, 0,       1, 'h16,    0, 'h12,    ins(4),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h20,    0, 'h12,    ins(4),  1));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 1, 'h100,   0, 0,       0, 'h20,    0, 'h12,    ins(4),  1));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       0, 'h100,   0, 'h12,    ins(4),  1));
        tbl.push_back(v(1, 0, 1, BAD,    0, 0, 0, 0,       0, 0,       0, 'h100,   0, 'h12,    ins(4),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h100,   0, 'h12,    ins(4),  1));
        tbl.push_back(v(1, 0, 1, ins(5), 0, 0, 0, 0,       0, 0,       0, 'h100,   0, 'h12,    ins(4),  1));
        // branch 0x200 and exception 0x80 together in HOLD, not ready
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 1, 'h200,   1, 'h80,    0, 'h100,   1, 'h100,   ins(5),  0));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h200,   0, 'h100,   ins(5),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h200,   0, 'h100,   ins(5),  1));
        tbl.push_back(v(1, 0, 1, ins(6), 0, 0, 0, 0,       0, 0,       0, 'h200,   0, 'h100,   ins(5),  1));
        // IFID stalled for 5 cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1, 0, 0, 0,  0, 0, 0, 0,       0, 0,       0, 'h200,   1, 'h200,   ins(6),  0));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, 'h200,   1, 'h200,   ins(6),  0));
        // no gnt for 4 cycles, exception to 0x40 in the 2nd
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h204,   0, 'h200,   ins(6),  1));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       1, 'h40,    1, 'h204,   0, 'h200,   ins(6),  1));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h40,    0, 'h200,   ins(6),  1));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h40,    0, 'h200,   ins(6),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h40,    0, 'h200,   ins(6),  1));
        tbl.push_back(v(1, 0, 1, ins(7), 0, 0, 0, 0,       0, 0,       0, 'h40,    0, 'h200,   ins(6),  1));
        // redirect together with acceptance: target wins over pc+4
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 1, 'h300,   0, 0,       0, 'h40,    1, 'h40,    ins(7),  0));
        // redirect coinciding with gnt: returned data dropped
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 1, 'h400,   0, 0,       1, 'h300,   0, 'h40,    ins(7),  1));
        tbl.push_back(v(1, 0, 1, BAD,    0, 0, 0, 0,       0, 0,       0, 'h400,   0, 'h40,    ins(7),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h400,   0, 'h40,    ins(7),  1));
        // redirect in the same cycle as rvalid: data discarded
        tbl.push_back(v(1, 0, 1, BAD,    0, 0, 1, 'h500,   0, 0,       0, 'h400,   0, 'h40,    ins(7),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, 'h500,   0, 'h40,    ins(7),  1));
        tbl.push_back(v(1, 0, 1, ins(8), 0, 0, 0, 0,       0, 0,       0, 'h500,   0, 'h40,    ins(7),  1));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, 'h500,   1, 'h500,   ins(8),  0));
        // PC wraps from 0xFFFF_FFFC to 0
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 1, TOP,     0, 0,       1, 'h504,   0, 'h500,   ins(8),  1));
        tbl.push_back(v(1, 1, 0, 0,      0, 0, 0, 0,       0, 0,       1, TOP,     0, 'h500,   ins(8),  1));
        tbl.push_back(v(1, 0, 1, ins(9), 0, 0, 0, 0,       0, 0,       0, TOP,     0, 'h500,   ins(8),  1));
        tbl.push_back(v(1, 0, 0, 0,      1, 0, 0, 0,       0, 0,       0, TOP,     1, TOP,     ins(9),  0));
        tbl.push_back(v(1, 0, 0, 0,      0, 0, 0, 0,       0, 0,       1, 0,       0, TOP,     ins(9),  1));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while a read is outstanding; the stale rvalid arrives in IDLE
        // and REQ and must be ignored. A redirect in IDLE sets the first PC.
        apply(v(1, 1, 0, 0,      0, 0, 0, 0,      0, 0,  1, 0,      0, TOP,    ins(9),  1));
        apply(v(0, 0, 0, 0,      0, 0, 0, 0,      0, 0,  0, 0,      0, TOP,    ins(9),  1));
        apply(v(1, 0, 1, BAD,    0, 0, 1, 'h600,  0, 0,  0, 0,      0, 0,      0,       0));
        apply(v(1, 0, 1, BAD,    0, 0, 0, 0,      0, 0,  1, 'h600,  0, 0,      0,       1));
        apply(v(1, 1, 0, 0,      0, 0, 0, 0,      0, 0,  1, 'h600,  0, 0,      0,       1));
        apply(v(1, 0, 1, ins(10), 0, 0, 0, 0,     0, 0,  0, 'h600,  0, 0,      0,       1));
        apply(v(1, 0, 0, 0,      0, 0, 0, 0,      0, 0,  0, 'h600,  1, 'h600,  ins(10), 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the PC selection logic, the instruction cache and the IFID register. It owns the fetch PC and issues one Icache read at a time using a req/gnt/rvalid handshake. It presents the returned instruction to IFID with a valid/ready handshake. Branch redirects from EX and exception redirects from Ctrl squash any in-flight or held fetch.

## Interface
- ADDR_WIDTH, 32, PC/address width
- START_PC, 32'h0000_0000, PC loaded at reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_branch_flag  in  1  branch redirect request
- ex_branch_pc  in  ADDR_WIDTH  branch target
- ctrl_excp_flag  in  1  exception redirect request
- ctrl_excp_pc  in  ADDR_WIDTH  exception vector
- ic_req  out  1  Icache read request
- ic_addr  out  ADDR_WIDTH  Icache read address (= fetch PC)
- ic_gnt  in  1  Icache accepted request this cycle
- ic_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt
- ic_rdata  in  32  instruction word
- if_valid  out  1  instruction available to IFID
- if_pc  out  ADDR_WIDTH  PC of presented instruction
- if_instr  out  32  presented instruction
- if_ready  in  1  IFID accepts (not stalled)
- if_16bit  in  1  decode: presented instruction is compressed; valid when if_valid
- busy  out  1  request outstanding (state REQ or WAIT)

## Operation
- States:
  - IDLE: only after reset.
  - REQ: ic_req=1.
  - WAIT: granted, awaiting rvalid.
  - HOLD: if_valid=1.
- Reset:
  - state=IDLE, pc=START_PC, drop=0.
  - ic_req=0, if_valid=0, if_pc=0, if_instr=0, busy=0.
- IDLE → REQ unconditionally.
- REQ: ic_addr=pc. ic_gnt=1 → WAIT.
- WAIT: ic_rvalid=1 and drop=0 → HOLD, registering if_pc=pc and if_instr=ic_rdata.
- HOLD: if_valid=1 until if_ready=1. On acceptance:
  - pc ← if_pc + (if_16bit ? 2 : 4), computed in ADDR_WIDTH, wrap modulo 2^ADDR_WIDTH.
  - → REQ.
- Redirect target: ex_branch_pc if ex_branch_flag, else ctrl_excp_pc. Branch wins over exception when both are set. In every state, pc ← target.
- Redirect behaviour per state:
  - REQ, no gnt this cycle: stay REQ. ic_addr shows new pc next cycle. The Icache interface permits address change before gnt.
  - REQ with gnt same cycle: → WAIT with drop=1.
  - WAIT: drop ← 1. If rvalid arrives the same cycle, discard it, clear drop, → REQ.
  - HOLD: if_valid ← 0 next cycle, → REQ. If if_ready is also 1, the handshake completes (IFID squashes it), but pc takes the redirect target, not pc+2/4.
  - IDLE: pc updated, → REQ.
- WAIT with drop=1 and rvalid: discard data, drop ← 0, → REQ with current pc.
- Only one outstanding Icache request. Further redirects during WAIT only update pc.

## Timing
- ic_req first high in the cycle after rst_n deasserts.
- gnt in cycle N → WAIT from N+1. rvalid in cycle M → if_valid=1 from M+1.
- Acceptance in cycle K → ic_req=1 in K+1 at the new pc.
- Minimum period: 3 cycles per instruction (REQ with immediate gnt, WAIT with rvalid at N+1, HOLD with ready).
- Redirect asserted in cycle R:
  - pc and ic_addr reflect the target in R+1.
  - No instruction fetched before R is presented after R.
- Reset while in WAIT: the controller ignores a later stale rvalid while in IDLE/REQ. The Icache is reset by the same rst_n.

## Test plan
- Reset, Icache always granting, rvalid 1 cycle after gnt, if_ready=1, if_16bit=0 → ic_addr sequence 0x0, 0x4, 0x8. if_valid one cycle in every 3.
- Present instr at 0x10 with if_16bit=1 and ready → next ic_addr=0x12. Then if_16bit=0 → 0x16.
- Branch to 0x100 while in WAIT for 0x20, rvalid 2 cycles later → 0x20 data never presented. Next ic_req at 0x100. if_pc=0x100.
- ex_branch_flag (0x200) and ctrl_excp_flag (0x80) in the same cycle during HOLD with if_ready=0 → if_valid drops next cycle. ic_addr=0x200.
- if_ready held 0 for 5 cycles in HOLD → if_valid, if_pc and if_instr stable. No ic_req issued.
- ic_gnt held 0 for 4 cycles, redirect to 0x40 in cycle 2 → ic_req stays high. ic_addr=0x40 from cycle 3. Gnt at 0x40.
